// File: rtl/psum_accumulator_pkg.sv
// Shared types and constants for the Swin partial-sum accumulator stage.
// Optional feature macro used by the top: PSUM_BIAS_EN (adds a per-group bias input).
package swin_acc_pkg;

    // Default configuration of the accumulator lane
    localparam int MAX_BEATS_DEF = 64;
    localparam int OUT_W_DEF     = 8;
    localparam int BEAT_W        = $clog2(MAX_BEATS_DEF + 1);

    // Saturation limits for a signed output of width out_w
    function automatic int sat_max(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int out_w);
        return -(1 << (out_w - 1));
    endfunction

    localparam int SAT_MAX = sat_max(OUT_W_DEF);
    localparam int SAT_MIN = sat_min(OUT_W_DEF);

    // Group FSM: collecting beats, then holding the result until accepted
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/psum_accumulator_requant_sat.sv
// Combinational requantizer: arithmetic right shift with round-half-up,
// then clamp to a signed OUT_W result. Shared with later nonlinear stages.
module requant_sat
    import swin_acc_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8,
    parameter int SHW   = 5
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic        [SHW-1:0]   shift_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    // One extra bit so adding the rounding constant can never wrap
    localparam logic signed [ACC_W:0] HI = (ACC_W + 1)'(sat_max(OUT_W));
    localparam logic signed [ACC_W:0] LO = (ACC_W + 1)'(sat_min(OUT_W));

    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;

    // Shift/round, then clamp into the output range
    always_comb begin
        wide   = {acc_i[ACC_W-1], acc_i};
        rnd    = '0;
        r      = wide;
        data_o = '0;
        sat_o  = 1'b0;
        if (shift_i == '0) begin
            r = wide;
        end else if (32'(shift_i) >= ACC_W) begin
            // Everything shifted out: only the sign survives, no rounding
            r = acc_i[ACC_W-1] ? '1 : '0;
        end else begin
            rnd = (ACC_W + 1)'(1) << (shift_i - SHW'(1));
            r   = (wide + rnd) >>> shift_i;
        end
        if (r > HI) begin
            data_o = HI[OUT_W-1:0];
            sat_o  = 1'b1;
        end else if (r < LO) begin
            data_o = LO[OUT_W-1:0];
            sat_o  = 1'b1;
        end else begin
            data_o = r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Per-lane accumulator behind the MAC adder tree: sums cfg_beats partial
// sums, requantizes the total and offers it downstream with valid/ready.
// Build option: define PSUM_BIAS_EN to add a signed cfg_bias preload.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready, and once out_valid is raised
// out_data/out_sat hold until the transfer completes.
module psum_accumulator
    import swin_acc_pkg::*;
#(
    parameter int K         = 15,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 8,
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int SHW       = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$clog2(MAX_BEATS+1)-1:0]     cfg_beats,
    input  logic [SHW-1:0]                     cfg_shift,
`ifdef PSUM_BIAS_EN
    input  logic signed [ACC_W-1:0]            cfg_bias,
`endif
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [K-1:0]                in_sum,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [OUT_W-1:0]            out_data,
    output logic                               out_sat,
    output logic                               busy,
    output state_t                             dbg_state
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    if (ACC_W < K + $clog2(MAX_BEATS)) begin : g_acc_w_check
        $error("psum_accumulator: ACC_W too small for K and MAX_BEATS");
    end

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         beats_q, beats_d;
    logic [SHW-1:0]           shift_q, shift_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic                     hs;
    logic                     last_beat;
    logic [CNT_W-1:0]         beats_eff;
    logic signed [ACC_W-1:0]  sum_ext;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [OUT_W-1:0]  rq_data;
    logic                     rq_sat;

`ifdef PSUM_BIAS_EN
    assign acc_base = cfg_bias;
`else
    assign acc_base = '0;
`endif

    assign in_ready  = (state_q != HOLD);
    assign hs        = in_valid && in_ready;
    assign sum_ext   = {{(ACC_W-K){in_sum[K-1]}}, in_sum};
    // A zero beat count still means one partial sum per group
    assign beats_eff = (cfg_beats == '0) ? CNT_W'(1) : cfg_beats;

    // Datapath: group config latch, accumulator, beat counter, last-beat detect
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        beats_d   = beats_q;
        shift_d   = shift_q;
        last_beat = 1'b0;
        if (hs) begin
            if (state_q == IDLE) begin
                beats_d   = beats_eff;
                shift_d   = cfg_shift;
                acc_d     = acc_base + sum_ext;
                cnt_d     = CNT_W'(1);
                last_beat = (beats_eff <= CNT_W'(1));
            end else begin
                acc_d     = acc_q + sum_ext;
                cnt_d     = cnt_q + CNT_W'(1);
                last_beat = (cnt_d >= beats_q);
            end
        end
    end

    // Requantize the total including the beat being accepted this cycle
    requant_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHW   (SHW)
    ) u_requant (
        .acc_i   (acc_d),
        .shift_i (shift_d),
        .data_o  (rq_data),
        .sat_o   (rq_sat)
    );

    // FSM next state and output register next values
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            IDLE:    if (hs) state_d = ACCUM;
            ACCUM:   state_d = ACCUM;
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (last_beat) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_data_d  = rq_data;
            out_sat_d   = rq_sat;
        end
    end

    // State and datapath registers; reset discards any partial group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            beats_q     <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            beats_q     <= beats_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sequential stage directly downstream of the combinational adder tree in the Swin MAC datapath.
- Each cycle the adder tree produces one signed partial sum, covering one slice of the input channels.
- This block accumulates cfg_beats consecutive partial sums into one dot-product result, requantizes it (shift, round, saturate) to OUT_W and hands it downstream with valid/ready.
- One instance per output lane.

Parameters:
K, 15, width of signed partial sum from adder tree
ACC_W, 24, accumulator width; elaboration check ACC_W >= K + $clog2(MAX_BEATS)
OUT_W, 8, signed output width after requantization
MAX_BEATS, 64, max partial sums per group
SHW, 5, width of cfg_shift

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_beats  in  $clog2(MAX_BEATS+1)  partial sums per group; sampled on first beat of group
cfg_shift  in  SHW  arithmetic right shift for requant; sampled on first beat
in_valid  in  1  partial sum valid
in_ready  out  1  block can accept partial sum
in_sum  in  K  signed partial sum from adder tree
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_W  signed requantized result
out_sat  out  1  result was clipped (qualified by out_valid)
busy  out  1  group in progress (ACCUM) or result pending (HOLD)

Behaviour:
- Reset (async assert, sync-released by the top): out_valid=0, out_data=0, out_sat=0, busy=0, accumulator=0, beat counter=0, state=IDLE.
- A reset mid-group discards the partial group.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE:
  - in_ready=1.
  - On a handshake (in_valid&in_ready), latch cfg_beats and cfg_shift; acc = sext(in_sum); cnt=1.
  - If the latched beats <= 1, go to HOLD; otherwise go to ACCUM.
  - cfg_beats=0 is treated as 1.
- ACCUM:
  - in_ready=1.
  - Each handshake: acc += sext(in_sum); cnt++.
  - On the handshake where cnt reaches beats, go to HOLD.
  - Cycles with in_valid=0 are bubbles; acc holds.
- Transition to HOLD: on the same clock edge, out_data/out_sat are registered from requant(final acc, including the last in_sum) and out_valid=1.
- Latency: result valid the cycle after the last beat is accepted.
- HOLD:
  - in_ready=0.
  - out_data and out_sat are stable while out_valid=1 and out_ready=0.
  - On out_ready, out_valid drops next cycle and state returns to IDLE.
- Throughput: a group of L beats takes L+1 cycles when out_ready is high.
- Requant arithmetic, computed on ACC_W+1 bits to avoid a rounding carry:
  - If s=0: r = acc.
  - Otherwise: r = (acc + (1<<(s-1))) >>> s, i.e. round half up.
  - If s >= ACC_W: result is 0 for acc >= 0 and -1 for acc < 0 (no rounding).
- Saturation: clamp r to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1]; out_sat=1 iff a clamp occurred.
- Accumulator cannot overflow by construction (ACC_W check).
- cfg_* changes mid-group are ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: PSUM_BIAS_EN.
- When defined:
  - Adds input port cfg_bias [ACC_W-1:0] (signed), sampled on the first beat.
  - First beat loads acc = cfg_bias + sext(in_sum); bias is applied before requant.
- When undefined: no cfg_bias port; acc starts from sext(in_sum).
- Timing and handshake are identical in both builds.

Decomposition:
- Package swin_acc_pkg:
  - state typedef (enum IDLE/ACCUM/HOLD);
  - localparams for saturation limits as functions of OUT_W;
  - BEAT_W = $clog2(MAX_BEATS+1).
- Sub-module requant_sat: purely combinational shift/round/saturate, parameters ACC_W/OUT_W/SHW, outputs data and sat flag. It is reusable by later softmax/GELU stages.
- The FSM, counter and accumulator stay in psum_accumulator.

Test Plan:
- cfg_beats=4, cfg_shift=0, in_sum=10,20,-5,7 back-to-back, out_ready=1 -> one cycle after the 4th beat: out_valid=1, out_data=32, out_sat=0; in_ready=0 for exactly one cycle.
- cfg_beats=3, cfg_shift=2, in_sum=3,3,0 -> acc=6, (6+2)>>>2 = out_data=2; the same with sums -3,-3,0 -> (-6+2)>>>2 = -1.
- cfg_beats=2, cfg_shift=0, in_sum=16383,16383 -> out_data=127, out_sat=1; sums -16384,-16384 -> out_data=-128, out_sat=1.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_data is stable, in_ready=0, the next group's in_valid is not accepted; when out_ready goes high the next group starts the cycle after.
- cfg_beats=0 with a single beat in_sum=-9 -> treated as 1, out_data=-9; bubbles (in_valid low 3 cycles) inside a 4-beat group do not change the sum.
- rst_n asserted after 2 of 4 beats -> outputs are immediately 0 and state is IDLE; a fresh group of 1 with in_sum=5 yields 5.
- PSUM_BIAS_EN build: cfg_bias=100, beats 1, in_sum=-1, cfg_shift=0 -> out_data=99 (per-build scenario).
